// File: rtl/counter_0_7.sv
// counter_0_7: free-running modulo-8 counter with a terminal-count flag.
// Ports: CLK clock, CLEAR async active-low clear, OUT high while count is 7.
module counter_0_7 (
  input  logic CLK,
  input  logic CLEAR,
  output logic OUT
);

  logic [2:0] r_cnt;
  logic       r_out;
  logic [2:0] w_nxt;
  logic       w_nxt_tc;

  // 3-bit add wraps 7->0 on its own.
  assign w_nxt    = r_cnt + 3'd1;
  assign w_nxt_tc = (w_nxt == 3'd7);

  // The flag is registered from the next-state decode. It rises with the
  // count reaching 7, and OUT is driven straight from a flop, so it cannot
  // glitch.
  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      r_cnt <= 3'd0;
      r_out <= 1'b0;
    end else begin
      r_cnt <= w_nxt;
      r_out <= w_nxt_tc;
    end
  end

  assign OUT = r_out;

endmodule

// File: tb/tb_counter_0_7.sv
// tb_counter_0_7: randomized checks of counter_0_7 against an edge-count model.
// Ports: none (drives CLK/CLEAR, observes OUT).
module tb_counter_0_7;

  logic clk;
  logic clear;
  logic out;

  int n_chk;
  int n_fail;
  int edges;

  counter_0_7 u_dut (
    .CLK   (clk),
    .CLEAR (clear),
    .OUT   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_out();
    return (edges % 8) == 7;
  endfunction

  // One rising edge, then update the model and check 1 unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (clear) edges++;
    #1;
    chk(tag, {31'd0, out}, {31'd0, exp_out()});
  endtask

  // Clear lands between edges; OUT must drop with no clock edge.
  task automatic async_clear(input string tag);
    #1;
    clear = 1'b0;
    edges = 0;
    #1;
    chk(tag, {31'd0, out}, 32'd0);
  endtask

  initial begin
    int hi_idx[$];
    int k;
    int n;
    n_chk  = 0;
    n_fail = 0;
    edges  = 0;
    clear  = 1'b0;

    #1;
    chk("reset_out", {31'd0, out}, 32'd0);
    repeat (2) tick("reset_hold");

    #1 clear = 1'b1;
    for (int i = 0; i < 20; i++) tick("count_seq");
    chk("count_edges", edges, 32'd20);

    async_clear("clr_mid");
    repeat (10) tick("clr_hold");

    #1 clear = 1'b1;
    repeat (7) tick("to_tc");
    chk("at_tc", {31'd0, out}, 32'd1);
    async_clear("clr_at_tc");
    tick("clr_tc_hold");
    #1 clear = 1'b1;
    repeat (6) tick("pre_tc");
    tick("tc_again");
    chk("tc_again_hi", {31'd0, out}, 32'd1);

    // Long run: pulse positions measured independently of the model.
    for (int i = 0; i < 64; i++) begin
      tick("long_run");
      if (out) hi_idx.push_back(i);
    end
    chk("long_pulses", hi_idx.size(), 32'd8);
    for (int i = 1; i < hi_idx.size(); i++)
      chk("long_gap", hi_idx[i] - hi_idx[i-1], 32'd8);
    chk("long_phase", edges % 8, 32'd7);

    // Random run lengths with random async clears.
    for (int it = 0; it < 150; it++) begin
      n = $urandom_range(0, 20);
      for (int j = 0; j < n; j++) tick("rand_run");
      if ($urandom_range(0, 2) == 0) begin
        async_clear("rand_clr");
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) tick("rand_hold");
        #1 clear = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
